// File: rtl/vsd_uart_pkg.sv
// Shared types and helpers for the UART transmitter: frame FSM state
// encoding and the clocks-per-bit calculation.
package vsd_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned BITS_PER_BYTE = 8;

  // Clock cycles per serial bit; integer truncation is intentional.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/vsd_sync_fifo.sv
// Single-clock byte FIFO with registered storage. Pushes into a full FIFO and
// pops from an empty one are ignored; pointers wrap modulo DEPTH.
module vsd_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("vsd_sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_MAX);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vsd_uart_tx.sv
// 8N1 UART transmitter fed by a byte FIFO. Frames go out back-to-back while
// bytes are queued; writes into a full FIFO are dropped and latch overflow.
module vsd_uart_tx
  import vsd_uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 12_000_000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  uart_data,
  input  logic        uart_valid,
  output logic        uart_ready,
  output logic        tx,
  output logic        busy,
  output logic        overflow,
  output uart_state_e state_dbg
);

  localparam int unsigned DIV   = calc_div(CLK_FREQ_HZ, BAUD);
  localparam int          CNT_W = $clog2(DIV) + 1;
  localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [2:0]       LAST_BIT = 3'(BITS_PER_BYTE - 1);

  if (DIV < 2) begin : g_bad_div
    $error("vsd_uart_tx: CLK_FREQ_HZ / BAUD must be at least 2");
  end

  // Valid/ready: a byte is taken at a clk edge where uart_valid and uart_ready
  // are both high; uart_valid with uart_ready low drops the byte and sets
  // overflow. uart_ready depends only on the registered FIFO count.
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  uart_state_e      state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  logic             fifo_push;
  logic             fifo_pop;
  logic [7:0]       fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;

  assign uart_ready = !fifo_full;
  assign fifo_push  = uart_valid && uart_ready && !rst;
  // A new frame is loaded either from idle or right at the end of a stop bit.
  assign fifo_pop   = !fifo_empty &&
                      ((state == IDLE) || (state == STOP && bit_cnt == '0));
  assign busy       = (state != IDLE) || (fifo_count != '0);
  assign state_dbg  = state;

  vsd_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (uart_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (uart_valid && !uart_ready) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      shift   <= '0;
      bit_cnt <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_pop) begin
            shift   <= fifo_dout;
            bit_cnt <= DIV_M1;
            tx      <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (bit_cnt == '0) begin
            bit_cnt <= DIV_M1;
            bit_idx <= '0;
            tx      <= shift[0];
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt - CNT_ONE;
          end
        end
        DATA: begin
          if (bit_cnt == '0) begin
            bit_cnt <= DIV_M1;
            if (bit_idx == LAST_BIT) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
            end
          end else begin
            bit_cnt <= bit_cnt - CNT_ONE;
          end
        end
        STOP: begin
          if (bit_cnt == '0) begin
            if (fifo_pop) begin
              shift   <= fifo_dout;
              bit_cnt <= DIV_M1;
              tx      <= 1'b0;
              state   <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt - CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vsd_uart_tx.sv
// Directed bench for vsd_uart_tx: a line decoder checks every frame against
// an expected-byte queue; timing and flag checks are made inline.
module tb_vsd_uart_tx;
  import vsd_uart_pkg::*;

  localparam int DIV  = 104;   // 12_000_000 / 115200, truncated
  localparam int DIV2 = 8;     // 1_000_000 / 115200, truncated

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  uart_data = '0;
  logic        uart_valid = 1'b0;
  logic        uart_ready, tx, busy, overflow;
  uart_state_e state_dbg;

  logic [7:0]  data2 = '0;
  logic        valid2 = 1'b0;
  logic        ready2, tx2, busy2, overflow2;
  uart_state_e state_dbg2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frames = 0;
  bit mon_en = 1'b1;
  bit b2b_chk = 1'b0;
  bit have_prev = 1'b0;
  int last_start = 0;
  logic [7:0] exp_q[$];

  vsd_uart_tx dut (
    .clk(clk), .rst(rst), .uart_data(uart_data), .uart_valid(uart_valid),
    .uart_ready(uart_ready), .tx(tx), .busy(busy), .overflow(overflow),
    .state_dbg(state_dbg)
  );

  vsd_uart_tx #(.CLK_FREQ_HZ(1_000_000), .BAUD(115200)) dut2 (
    .clk(clk), .rst(rst), .uart_data(data2), .uart_valid(valid2),
    .uart_ready(ready2), .tx(tx2), .busy(busy2), .overflow(overflow2),
    .state_dbg(state_dbg2)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: observed cyc=%0d required finish earlier", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk(tag, n < budget, 1);
  endtask

  // Line decoder: samples mid-bit on the falling clock edge.
  initial begin
    int s;
    logic [7:0] byte_v;
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
        s = cyc;
        if (b2b_chk && have_prev) chk("frame_spacing", s - last_start, 10 * DIV);
        have_prev = 1'b1;
        last_start = s;
        repeat (DIV / 2) @(negedge clk);
        chk("start_bit", tx, 0);
        for (int b = 0; b < 8; b++) begin
          repeat (DIV) @(negedge clk);
          byte_v[b] = tx;
        end
        repeat (DIV) @(negedge clk);
        chk("stop_bit", tx, 1);
        chk("frame_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("frame_data", byte_v, exp_q.pop_front());
        frames++;
      end
    end
  end

  initial begin
    int n, t0, f0, low, fall;
    logic [9:0] bits2;

    // Reset state
    step();
    do_reset();
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ready", uart_ready, 1);
    chk("rst_overflow", overflow, 0);

    // Single byte 0x55: tx falls one edge after the push edge
    uart_data = 8'h55; uart_valid = 1'b1;
    step();
    uart_valid = 1'b0;
    exp_q.push_back(8'h55);
    chk("s1_tx_push_edge", tx, 1);
    step();
    chk("s1_tx_fall", tx, 0);
    n = 0;
    while (busy && n < 2000) begin step(); n++; end
    chk("s1_busy_len", n, 10 * DIV);
    chk("s1_queue_drained", exp_q.size(), 0);

    // 20 back-to-back writes: first byte leaves the FIFO at once, 16 more fill it
    do_reset();
    have_prev = 1'b0; b2b_chk = 1'b1; f0 = frames;
    for (int i = 0; i < 20; i++) begin
      uart_data = 8'($urandom_range(0, 255));
      uart_valid = 1'b1;
      step();
      if (i < 17) exp_q.push_back(uart_data);
      chk("s2_ready", uart_ready, (i < 16) ? 1 : 0);
      chk("s2_overflow", overflow, (i < 17) ? 0 : 1);
    end
    uart_valid = 1'b0;
    wait_idle("s2_idle", 17 * 10 * DIV + 200);
    chk("s2_frames", frames - f0, 17);
    chk("s2_overflow_sticky", overflow, 1);

    // 0xA3 then 0x00 pushed mid-frame: second start follows the first stop
    do_reset();
    have_prev = 1'b0; f0 = frames;
    uart_data = 8'hA3; uart_valid = 1'b1; step(); uart_valid = 1'b0;
    exp_q.push_back(8'hA3);
    repeat (500) step();
    uart_data = 8'h00; uart_valid = 1'b1; step(); uart_valid = 1'b0;
    exp_q.push_back(8'h00);
    wait_idle("s3_idle", 3 * 10 * DIV);
    chk("s3_frames", frames - f0, 2);
    b2b_chk = 1'b0;

    // Reset 300 cycles into a frame with three bytes queued
    mon_en = 1'b0;
    t0 = 0;
    for (int i = 0; i < 4; i++) begin
      uart_data = 8'(8'h10 + i); uart_valid = 1'b1; step();
      if (i == 0) t0 = cyc;
    end
    uart_valid = 1'b0;
    while (cyc < t0 + 300) step();
    chk("s4_mid_frame", tx, 0);
    rst = 1'b1; uart_data = 8'hFF; uart_valid = 1'b1;
    step();
    chk("s4_tx", tx, 1);
    chk("s4_busy", busy, 0);
    chk("s4_ready", uart_ready, 1);
    rst = 1'b0; uart_valid = 1'b0;
    low = 0;
    repeat (3000) begin
      step();
      if (tx !== 1'b1) low++;
    end
    chk("s4_no_frames", low, 0);
    chk("s4_busy_after", busy, 0);
    mon_en = 1'b1;

    // Full FIFO, write coinciding with the stop-end pop is still dropped
    do_reset();
    have_prev = 1'b0; b2b_chk = 1'b1; f0 = frames;
    t0 = 0;
    for (int i = 0; i < 17; i++) begin
      uart_data = 8'($urandom_range(0, 255)); uart_valid = 1'b1;
      step();
      if (i == 0) t0 = cyc;
      exp_q.push_back(uart_data);
    end
    uart_valid = 1'b0;
    chk("s5_full_ready", uart_ready, 0);
    while (cyc < t0 + 10 * DIV) step();
    chk("s5_pre_overflow", overflow, 0);
    chk("s5_pre_ready", uart_ready, 0);
    uart_data = 8'hEE; uart_valid = 1'b1;
    step();
    uart_valid = 1'b0;
    chk("s5_overflow", overflow, 1);
    chk("s5_ready_after_pop", uart_ready, 1);
    wait_idle("s5_idle", 17 * 10 * DIV + 200);
    chk("s5_frames", frames - f0, 17);
    b2b_chk = 1'b0;

    // DIV=8 instance: 80-cycle frame
    data2 = 8'h3C; valid2 = 1'b1; step(); valid2 = 1'b0;
    step();
    chk("d8_tx_fall", tx2, 0);
    fall = cyc;
    for (int k = 0; k < 10; k++) begin
      repeat ((k == 0) ? DIV2 / 2 : DIV2) step();
      bits2[k] = tx2;
    end
    chk("d8_start", bits2[0], 0);
    chk("d8_data", bits2[8:1], 8'h3C);
    chk("d8_stop", bits2[9], 1);
    while (busy2 && cyc - fall < 200) step();
    chk("d8_frame_len", cyc - fall, 10 * DIV2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vsd_uart_tx.md
VSD_UART_TX -- requirements
Module: vsd_uart_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 12_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, serial line rate in bits per second.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, transmit byte FIFO depth; power of two, at least 2.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all logic on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset; synchronous, active-high.
REQ-006 SHALL have port uart_data, input, 8 bits: byte to transmit, qualified by uart_valid.
REQ-007 SHALL have port uart_valid, input, 1 bit: single-cycle write strobe from the AXI bridge.
REQ-008 SHALL have port uart_ready, output, 1 bit: FIFO not full; firmware polls its inverse as the busy bit.
REQ-009 SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-010 SHALL have port busy, output, 1 bit: FIFO non-empty or frame in progress.
REQ-011 SHALL have port overflow, output, 1 bit: sticky; set when a byte is dropped.

Function
REQ-012 SHALL derive DIV = CLK_FREQ_HZ / BAUD (integer truncation) as clock cycles per bit; elaboration SHALL fail if DIV < 2.
REQ-013 SHALL push uart_data into the FIFO at a clk edge where uart_valid=1 and uart_ready=1.
REQ-014 SHALL drive uart_ready = (count != FIFO_DEPTH) from the registered count only; a pop in the same cycle SHALL NOT admit a push into a full FIFO.
REQ-015 SHALL drop uart_valid when uart_ready=0, without changing FIFO contents, and set overflow=1 at that edge.
REQ-016 SHALL hold overflow at 1 until rst.
REQ-017 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-018 IDLE: with FIFO non-empty, SHALL pop the head byte into the shift register, load the bit counter with DIV-1, set tx=0 and enter START, all at one edge.
REQ-019 SHALL make a byte pushed into an empty FIFO at edge N visible no earlier than edge N+1, so tx falls at edge N+1.
REQ-020 START: SHALL hold tx=0 for DIV cycles, then enter DATA.
REQ-021 DATA: SHALL send 8 bits LSB first, DIV cycles each, then enter STOP.
REQ-022 STOP: SHALL hold tx=1 for DIV cycles.
REQ-023 STOP end with FIFO non-empty: SHALL pop and enter START at the same edge, so there is no idle gap between frames.
REQ-024 STOP end with FIFO empty: SHALL return to IDLE.
REQ-025 SHALL make each frame exactly 10*DIV cycles.
REQ-026 SHALL drive tx from a register only, never combinationally.
REQ-027 SHALL drive busy = (state != IDLE) or (count != 0).
REQ-028 SHALL keep count width at log2(FIFO_DEPTH)+1 bits; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-029 On a simultaneous push and pop, SHALL leave count unchanged.

Reset
REQ-030 On rst=1 at an edge, SHALL set state=IDLE, tx=1, FIFO empty, overflow=0, bit counters=0, busy=0, uart_ready=1.
REQ-031 Reset mid-frame SHALL abort the frame, with tx=1 from that edge and queued bytes discarded.
REQ-032 SHALL ignore uart_valid during rst=1.

Structure
REQ-033 Package vsd_uart_pkg SHALL hold the FSM state enum (2 bits) and the DIV-computation function.
REQ-034 The FIFO SHALL be sub-module vsd_sync_fifo, with parameters WIDTH and DEPTH, ports push/pop/din/dout/full/empty/count, and registered storage.
REQ-035 The FSM, baud counter and shift register SHALL live in vsd_uart_tx.

Verification
REQ-036 Single byte 0x55 with DIV=104: tx low at edge N+1; bit boundaries every 104 cycles; sampled mid-bit 0,1,0,1,0,1,0,1,0,1; busy low after 1040 cycles.
REQ-037 20 consecutive uart_valid pulses into an idle block: 17 accepted, 3 dropped, overflow=1, uart_ready=0 after edge 16; 17 frames emitted back-to-back, each 1040 cycles, no gap.
REQ-038 Byte 0xA3 followed by byte 0x00 pushed 500 cycles later: second START begins exactly at the first frame's STOP end; decoded bytes 0xA3, 0x00.
REQ-039 rst asserted at cycle 300 of a frame with 3 bytes queued: tx=1 next edge, busy=0, uart_ready=1, no further frames.
REQ-040 Full FIFO with a pop coinciding with uart_valid: that byte dropped, overflow=1, count unchanged minus the pop.
REQ-041 CLK_FREQ_HZ=1_000_000, BAUD=115200: DIV=8, frame exactly 80 cycles.
